fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch front-end; initiator side of the decode unit's compute_req/compute_valid/branch_flag/new_pc interface.
- Owns the program counter and reads instruction words from instruction memory over a four-phase req/valid handshake.
- Presents each word to decode, waits for completion, then advances the PC: sequential (PC+4) or redirected to new_pc when branch_flag is set.
- Sits between instruction memory and decode; provides an instruction-retired count for debug.

Parameters:
- DATA_WIDTH, 32, instruction/data word width
- ADDR_WIDTH, 32, PC and instruction address width
- RESET_PC, 32'h0000_0000, PC value loaded at reset

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- fetch_enable  input  1  run control; 0 = stop after current instruction
- imem_req  output  1  instruction read request
- imem_addr  output  ADDR_WIDTH  read address, equals pc
- imem_valid  input  1  read data valid (responder handshake)
- imem_rdata  input  DATA_WIDTH  instruction word
- inst  output  DATA_WIDTH  latched instruction to decode
- compute_req  output  1  execute request to decode
- compute_valid  input  1  decode completion
- branch_flag  input  1  decode: take new_pc
- new_pc  input  DATA_WIDTH  decode: redirect target
- pc  output  ADDR_WIDTH  current instruction address
- instret  output  32  retired-instruction counter
- busy  output  1  high in any state other than S_IDLE/S_HALT
- fetch_error  output  1  sticky misaligned-target flag (feature only; tied 0 otherwise)

Behaviour:
- Reset (rst=0, async): state S_IDLE; pc=imem_addr=RESET_PC; inst=0; imem_req=0; compute_req=0; instret=0; busy=0; fetch_error=0. A reset mid-transaction drops both requests immediately; no PC update or count.
- Outputs are Moore: imem_req=(state==S_FETCH_REQ), compute_req=(state==S_EXEC_REQ), imem_addr=pc.
- S_IDLE: fetch_enable=1 -> S_FETCH_REQ next edge; else stay.
- S_FETCH_REQ: hold imem_req and imem_addr stable. On imem_valid=1, latch inst<=imem_rdata and go to S_FETCH_REL.
- S_FETCH_REL: wait for imem_valid=0, then go to S_EXEC_REQ. Four-phase: a new request is never raised while valid is still high.
- S_EXEC_REQ: inst stays stable until compute_valid=1. In that cycle:
  - sample branch_flag/new_pc;
  - pc <= branch_flag ? new_pc[ADDR_WIDTH-1:0] : pc+4 (mod 2^ADDR_WIDTH, wraps at max);
  - instret <= instret+1 (wraps at 2^32-1 -> 0);
  - go to S_EXEC_REL.
- S_EXEC_REL: compute_req low. Wait for compute_valid=0, then S_FETCH_REQ if fetch_enable=1, else S_IDLE. Decode holds compute_valid high while compute_req is high, so the request must drop first.
- fetch_enable sampled only in S_IDLE and S_EXEC_REL; deassertion never aborts an in-flight handshake.
- Response arriving in the same cycle as the request is legal; minimum cost is 4 states per instruction plus responder latency.
- imem_valid high in S_IDLE or S_EXEC_*: ignored. compute_valid high in S_FETCH_* or S_IDLE: ignored.
- new_pc and pc+4 are each truncated to ADDR_WIDTH.

Optional Feature:
FETCH_MISALIGN_TRAP_EN
- Defined: in S_EXEC_REQ, if the selected next PC has [1:0]!=0, pc is not updated and instret still increments. The unit sets fetch_error=1 (sticky) and enters S_HALT, where requests stay low and busy=0. Only reset exits S_HALT.
- Undefined: the next PC is written with bits [1:0] forced to 00; S_HALT is absent; fetch_error is tied 0.

Test Plan:
- Reset then fetch_enable=1; responder returns 32'h00500093 with 1-cycle latency -> imem_req rises with imem_addr=0, inst=32'h00500093, compute_req rises only after imem_valid falls.
- Decode returns compute_valid with branch_flag=0 -> pc=4, instret=1; compute_req falls the cycle after compute_valid; next imem_req waits until compute_valid=0.
- branch_flag=1, new_pc=32'h0000_0100 -> next imem_addr=0x100; instret increments.
- fetch_enable dropped during S_FETCH_REQ -> instruction completes, pc=4, unit returns to S_IDLE, busy=0, no further imem_req.
- rst=0 asserted during S_EXEC_REQ with pc=0x40 -> compute_req drops asynchronously, pc=RESET_PC, instret=0.
- FETCH_MISALIGN_TRAP_EN: new_pc=0x102 with branch_flag=1 -> fetch_error=1, pc unchanged, no new imem_req. Without the macro -> pc=0x100.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: owns the PC, reads imem and hands each word to decode (four-phase handshakes).
// Build macro FETCH_MISALIGN_TRAP_EN: misaligned next PC halts the unit and sets a sticky fetch_error.
module fetch_unit #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(32'h0000_0000)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_enable,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_valid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] inst,
    output logic                  compute_req,
    input  logic                  compute_valid,
    input  logic                  branch_flag,
    input  logic [DATA_WIDTH-1:0] new_pc,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [31:0]           instret,
    output logic                  busy,
    output logic                  fetch_error
);

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH_REQ = 3'd1,
        S_FETCH_REL = 3'd2,
        S_EXEC_REQ  = 3'd3,
        S_EXEC_REL  = 3'd4
`ifdef FETCH_MISALIGN_TRAP_EN
        , S_HALT    = 3'd5
`endif
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_inst;
    logic [31:0]           r_instret;
    logic                  r_imem_req;
    logic                  r_compute_req;
    logic                  r_busy;

    // Next-PC candidate: redirect target or sequential, both truncated to ADDR_WIDTH
    logic [ADDR_WIDTH-1:0] w_pc_sel;
    assign w_pc_sel = branch_flag ? new_pc[ADDR_WIDTH-1:0] : r_pc + PC_STEP;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_fetch_error;
    logic w_misaligned;
    assign w_misaligned = |w_pc_sel[1:0];
    assign fetch_error  = r_fetch_error;
`else
    logic [ADDR_WIDTH-1:0] w_pc_aligned;
    assign w_pc_aligned = w_pc_sel & ~ADDR_WIDTH'(3);
    assign fetch_error  = 1'b0;
`endif

    // Single-process FSM; request/busy outputs are registered alongside the state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_inst        <= '0;
            r_instret     <= '0;
            r_imem_req    <= 1'b0;
            r_compute_req <= 1'b0;
            r_busy        <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            r_fetch_error <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (fetch_enable) begin
                        r_state    <= S_FETCH_REQ;
                        r_imem_req <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_FETCH_REQ: begin
                    if (imem_valid) begin
                        r_inst     <= imem_rdata;
                        r_imem_req <= 1'b0;
                        r_state    <= S_FETCH_REL;
                    end
                end
                S_FETCH_REL: begin
                    if (!imem_valid) begin
                        r_compute_req <= 1'b1;
                        r_state       <= S_EXEC_REQ;
                    end
                end
                S_EXEC_REQ: begin
                    if (compute_valid) begin
                        r_instret     <= r_instret + 32'd1;
                        r_compute_req <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                        if (w_misaligned) begin
                            r_fetch_error <= 1'b1;
                            r_busy        <= 1'b0;
                            r_state       <= S_HALT;
                        end else begin
                            r_pc    <= w_pc_sel;
                            r_state <= S_EXEC_REL;
                        end
`else
                        r_pc    <= w_pc_aligned;
                        r_state <= S_EXEC_REL;
`endif
                    end
                end
                S_EXEC_REL: begin
                    // Decode holds compute_valid until it sees the request drop
                    if (!compute_valid) begin
                        if (fetch_enable) begin
                            r_imem_req <= 1'b1;
                            r_state    <= S_FETCH_REQ;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                S_HALT: begin
                    r_state <= S_HALT;
                end
`endif
                default: begin
                    r_state       <= S_IDLE;
                    r_imem_req    <= 1'b0;
                    r_compute_req <= 1'b0;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign inst        = r_inst;
    assign compute_req = r_compute_req;
    assign instret     = r_instret;
    assign busy        = r_busy;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table, directed corner sequences, randomized run vs. a reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_enable;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        compute_req;
    logic        compute_valid;
    logic        branch_flag;
    logic [31:0] new_pc;
    logic [31:0] pc;
    logic [31:0] instret;
    logic        busy;
    logic        fetch_error;

    int total = 0;
    int bad   = 0;

    fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_enable (fetch_enable),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_valid   (imem_valid),
        .imem_rdata   (imem_rdata),
        .inst         (inst),
        .compute_req  (compute_req),
        .compute_valid(compute_valid),
        .branch_flag  (branch_flag),
        .new_pc       (new_pc),
        .pc           (pc),
        .instret      (instret),
        .busy         (busy),
        .fetch_error  (fetch_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        int          mlat;
        int          clat;
        logic        br;
        logic [31:0] npc;
        logic [31:0] exp_pc;
        logic [31:0] exp_ret;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural next-PC rule: target or PC+4 in 32-bit arithmetic, low bits cleared when no trap
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic br, input logic [31:0] npc);
        logic [31:0] t;
        t = br ? npc : cur + 32'd4;
`ifndef FETCH_MISALIGN_TRAP_EN
        t = {t[31:2], 2'b00};
`endif
        return t;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        fetch_enable = 1'b0;
        imem_valid = 1'b0;
        compute_valid = 1'b0;
        branch_flag = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Fetch handshake up to the point where compute_req is raised
    task automatic fetch_phase(input logic [31:0] word, input int mlat, input logic [31:0] exp_addr, input logic fen);
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_rise", 64'(imem_req), 64'(1));
        chk("fetch_addr", 64'(imem_addr), 64'(exp_addr));
        chk("busy_fetch", 64'(busy), 64'(1));
        fetch_enable = fen;
        repeat (mlat) @(negedge clk);
        chk("req_hold", 64'(imem_req), 64'(1));
        imem_valid = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        chk("req_drop", 64'(imem_req), 64'(0));
        chk("inst_latch", 64'(inst), 64'(word));
        imem_rdata = $urandom;
        @(negedge clk);
        chk("four_phase", 64'(compute_req), 64'(0));
        imem_valid = 1'b0;
        @(negedge clk);
        chk("creq_rise", 64'(compute_req), 64'(1));
    endtask

    // Decode side: completion, PC/count update, then four-phase release
    task automatic exec_phase(input logic [31:0] word, input int clat, input logic br, input logic [31:0] npc,
                              input logic [31:0] exp_pc, input logic [31:0] exp_ret);
        repeat (clat) begin
            imem_valid = 1'($urandom);
            imem_rdata = $urandom;
            @(negedge clk);
        end
        chk("inst_stable", 64'(inst), 64'(word));
        chk("creq_hold", 64'(compute_req), 64'(1));
        imem_valid = 1'b0;
        compute_valid = 1'b1;
        branch_flag = br;
        new_pc = npc;
        @(negedge clk);
        chk("creq_drop", 64'(compute_req), 64'(0));
        chk("pc_next", 64'(pc), 64'(exp_pc));
        chk("instret", 64'(instret), 64'(exp_ret));
        branch_flag = 1'b0;
        new_pc = $urandom;
        @(negedge clk);
        chk("wait_cv_low", 64'(imem_req), 64'(0));
        compute_valid = 1'b0;
    endtask

    vec_t        vecs[6];
    logic [31:0] cur_pc;
    logic [31:0] m_pc;
    logic [31:0] m_ret;

    initial begin
        vecs[0] = '{32'h0050_0093, 1, 0, 1'b0, 32'h0,         32'h0000_0004, 32'd1};
        vecs[1] = '{32'h1234_5678, 0, 2, 1'b1, 32'h0000_0100, 32'h0000_0100, 32'd2};
        vecs[2] = '{32'hDEAD_BEEF, 3, 1, 1'b0, 32'h0,         32'h0000_0104, 32'd3};
        vecs[3] = '{32'h0000_0013, 2, 0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'd4};
        vecs[4] = '{32'hCAFE_F00D, 0, 3, 1'b0, 32'h0,         32'h0000_0000, 32'd5};
        vecs[5] = '{32'h0A0B_0C0D, 1, 1, 1'b1, 32'h0000_0040, 32'h0000_0040, 32'd6};

        rst = 1'b0;
        fetch_enable = 1'b0;
        imem_valid = 1'b0;
        imem_rdata = '0;
        compute_valid = 1'b0;
        branch_flag = 1'b0;
        new_pc = '0;
        @(negedge clk);
        chk("rst_imem_req", 64'(imem_req), 64'(0));
        chk("rst_creq", 64'(compute_req), 64'(0));
        chk("rst_pc", 64'(pc), 64'(0));
        chk("rst_addr", 64'(imem_addr), 64'(0));
        chk("rst_inst", 64'(inst), 64'(0));
        chk("rst_instret", 64'(instret), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_ferr", 64'(fetch_error), 64'(0));

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_hold", 64'(imem_req), 64'(0));

        // Vector table from reset PC
        fetch_enable = 1'b1;
        cur_pc = 32'h0;
        for (int i = 0; i < 6; i++) begin
            fetch_phase(vecs[i].word, vecs[i].mlat, cur_pc, 1'b1);
            exec_phase(vecs[i].word, vecs[i].clat, vecs[i].br, vecs[i].npc, vecs[i].exp_pc, vecs[i].exp_ret);
            cur_pc = vecs[i].exp_pc;
        end

        // fetch_enable dropped mid-fetch: instruction completes, then idle
        fetch_phase(32'h1111_1111, 1, 32'h40, 1'b0);
        exec_phase(32'h1111_1111, 1, 1'b0, 32'h0, 32'h44, 32'd7);
        @(negedge clk);
        chk("stop_busy", 64'(busy), 64'(0));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stop_no_req", 64'(imem_req), 64'(0));
        end

        // Asynchronous reset while in S_EXEC_REQ at pc=0x40
        fetch_enable = 1'b1;
        fetch_phase(32'h2222_2222, 0, 32'h44, 1'b1);
        exec_phase(32'h2222_2222, 0, 1'b1, 32'h40, 32'h40, 32'd8);
        fetch_phase(32'h3333_3333, 0, 32'h40, 1'b1);
        #2 rst = 1'b0;
        fetch_enable = 1'b0;
        #1;
        chk("arst_creq", 64'(compute_req), 64'(0));
        chk("arst_pc", 64'(pc), 64'(0));
        chk("arst_instret", 64'(instret), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Misaligned redirect target
        fetch_enable = 1'b1;
        fetch_phase(32'h4444_4444, 0, 32'h0, 1'b1);
`ifdef FETCH_MISALIGN_TRAP_EN
        compute_valid = 1'b1;
        branch_flag = 1'b1;
        new_pc = 32'h0000_0102;
        @(negedge clk);
        chk("trap_ferr", 64'(fetch_error), 64'(1));
        chk("trap_pc", 64'(pc), 64'(0));
        chk("trap_instret", 64'(instret), 64'(1));
        chk("trap_busy", 64'(busy), 64'(0));
        compute_valid = 1'b0;
        branch_flag = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("halt_no_req", 64'(imem_req | compute_req), 64'(0));
        end
`else
        exec_phase(32'h4444_4444, 0, 1'b1, 32'h0000_0102, 32'h0000_0100, 32'd1);
        chk("no_trap_ferr", 64'(fetch_error), 64'(0));
`endif

        // Randomized run against the reference model
        do_reset();
        m_pc = 32'h0;
        m_ret = 32'h0;
        fetch_enable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [31:0] w;
            logic [31:0] npc;
            logic        br;
            logic        fen;
            w   = $urandom;
            br  = 1'($urandom);
            fen = ($urandom_range(0, 3) != 0);
            npc = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
            npc[1:0] = 2'b00;
`endif
            fetch_phase(w, $urandom_range(0, 3), m_pc, fen);
            m_pc  = model_next(m_pc, br, npc);
            m_ret = m_ret + 32'd1;
            exec_phase(w, $urandom_range(0, 3), br, npc, m_pc, m_ret);
            if (!fen) begin
                @(negedge clk);
                chk("rnd_idle_busy", 64'(busy), 64'(0));
                chk("rnd_idle_req", 64'(imem_req), 64'(0));
                fetch_enable = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
